// File: rtl/gpio_hex_display.sv
// gpio_hex_display
// Shows the CPU's 32-bit gpio_out word as 8 hex digits on a common-anode,
// time-multiplexed seven-segment display.
//
// Scan structure:
//   cnt  counts 0..SCAN_DIV-1 inside one digit slot; its wrap is the "tick".
//   idx  selects the digit being driven (0 = rightmost) and advances on tick.
//   snap is a copy of gpio_word taken at the first cycle of every frame
//        (idx==0, cnt==0), so all eight digits of one frame come from the
//        same word. hold suppresses that load and freezes the display.
//
// Output timing: an/seg/frame_done are registered. They are computed from
// the current (cnt, idx, snap), so they appear one cycle after those values.
// The first GUARD_CYC cycles of each slot keep every anode off. This lets
// the previous digit's segment drive die away before the next anode turns
// on (ghosting guard).
//
// All outputs are active-low except frame_done. an is never more than
// one-hot-low, because it is built from a single shifted bit.
module gpio_hex_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_word,
    input  logic        blank_lz,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    // Prescaler width; SCAN_DIV >= 2 guarantees at least one bit.
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_V  = CW'(GUARD_CYC);

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Registered state
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [2:0]    idx_q,  idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    an_q,   an_d;
    logic [6:0]    seg_q,  seg_d;
    logic          fd_q,   fd_d;

    // Combinational helpers
    logic          tick;
    logic          frame_start;
    logic          in_guard;
    logic [3:0]    nibble;
    logic [7:0]    upper_zero;
    logic          digit_blank;

    // Prescaler and digit index: the slot ends on tick, and digit 7 wraps back to 0.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        fd_d  = tick && (idx_q == 3'd7);
    end

    // Frame-coherent snapshot: load only in the first cycle of a frame, unless held.
    always_comb begin
        frame_start = (idx_q == 3'd0) && (cnt_q == '0);
        snap_d      = (frame_start && !hold) ? gpio_word : snap_q;
    end

    // Leading-zero detection on the snapshot.
    // upper_zero[i] is set when nibbles i..7 are all zero.
    always_comb begin
        upper_zero    = '0;
        upper_zero[7] = (snap_q[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (snap_q[4*i +: 4] == 4'h0);
        end
        // Digit 0 always stays lit, so an all-zero word still shows "0".
        digit_blank = blank_lz && (idx_q != 3'd0) && upper_zero[idx_q];
    end

    // Next display drive: dark during the guard window or for a blanked digit.
    always_comb begin
        in_guard = (cnt_q < GUARD_V);
        nibble   = snap_q[{idx_q, 2'b00} +: 4];
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        if (!in_guard && !digit_blank) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(nibble);
        end
    end

    // State and output registers; async reset puts the display dark and the scan at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fd_q   <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Bench for gpio_hex_display with a short scan (SCAN_DIV=4, GUARD_CYC=1).
// A reference model computes the expected an/seg/frame_done after every
// rising edge. It uses the time elapsed since reset release and the
// frame-level display rules. The model pushes each expectation into
// exp_q, and a monitor on the falling edge pops and compares it.
// Directed frame captures check the documented digit patterns.
module tb_gpio_hex_display;

    localparam int SD    = 4;
    localparam int GC    = 1;
    localparam int FRAME = 8 * SD;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_word;
    logic        blank_lz;
    logic        hold;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    gpio_hex_display #(
        .SCAN_DIV  (SD),
        .GUARD_CYC (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_word  (gpio_word),
        .blank_lz   (blank_lz),
        .hold       (hold),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Segment table straight from the display decode list.
    logic [6:0] hex_tab [16];
    initial begin
        hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
        hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
        hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
        hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
    end

    // ---------------- reference model ----------------
    // m_e is the number of edges seen since reset release. The slot position,
    // the digit and the frame position all follow from it by division.
    logic [15:0] exp_q [$];
    int          m_e    = 0;
    logic [31:0] m_snap = '0;

    always @(posedge clk) begin : model
        int          pos;
        int          dig;
        logic [31:0] sh;
        logic [3:0]  nib;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_fd;
        if (!rst) begin
            m_e    = 0;
            m_snap = '0;
            exp_q.push_back({8'hFF, 7'h7F, 1'b0});
        end else begin
            pos   = m_e % SD;
            dig   = (m_e / SD) % 8;
            sh    = m_snap >> (4 * dig);
            nib   = sh[3:0];
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            if (pos >= GC && !(blank_lz && dig > 0 && sh == 32'h0)) begin
                e_an  = ~(8'h01 << dig);
                e_seg = hex_tab[nib];
            end
            e_fd = ((m_e % FRAME) == FRAME - 1);
            if ((m_e % FRAME) == 0 && !hold) m_snap = gpio_word;
            exp_q.push_back({e_an, e_seg, e_fd});
            m_e++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int since_fd = 0;
    bit fd_valid = 1'b0;

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            if (rst) check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            if (!rst) e = {8'hFF, 7'h7F, 1'b0};
            check("scan_out", {16'h0, an, seg, frame_done}, {16'h0, e});
        end
        check("an_onehot", {31'b0, ($countones(~an) <= 1)}, 32'd1);
        if (!rst) begin
            fd_valid = 1'b0;
            since_fd = 0;
        end else begin
            since_fd++;
            if (frame_done) begin
                if (fd_valid) check("fd_period", since_fd, FRAME);
                fd_valid = 1'b1;
                since_fd = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] cap_on;
    logic [6:0] cap_seg [8];

    task automatic sync_fd();
        bit got = 1'b0;
        for (int k = 0; k < FRAME + 8; k++) begin
            @(negedge clk); #1;
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("sync_fd_timeout", 32'd0, 32'd1);
    endtask

    // Records which digits light up over one whole frame. The frame starts
    // right after the previous frame_done sample and ends at its own
    // frame_done. gpio_word is set to new_word at sample change_at.
    task automatic capture_frame(input int change_at, input logic [31:0] new_word);
        bit got = 1'b0;
        cap_on = '0;
        for (int i = 0; i < 8; i++) cap_seg[i] = '0;
        for (int k = 0; k < FRAME + 8; k++) begin
            @(negedge clk); #1;
            if (an != 8'hFF) begin
                for (int i = 0; i < 8; i++) begin
                    if (!an[i]) begin
                        cap_on[i]  = 1'b1;
                        cap_seg[i] = seg;
                    end
                end
            end
            if (k == change_at) gpio_word = new_word;
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] mask, input logic [55:0] segs);
        check({tag, "_en"}, {24'h0, cap_on}, {24'h0, mask});
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) check($sformatf("%s_seg%0d", tag, i), {25'h0, cap_seg[i]}, {25'h0, segs[7*i +: 7]});
        end
    endtask

    task automatic reset_mid_slot(input int wait_cyc);
        repeat (wait_cyc) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_an",  {24'h0, an},  32'h0000_00FF);
        check("rst_seg", {25'h0, seg}, 32'h0000_007F);
        check("rst_fd",  {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rel_c1_an", {24'h0, an}, 32'h0000_00FF);
        @(posedge clk); #1;
        check("rel_c2_an", {24'h0, an}, 32'h0000_00FE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        gpio_word = 32'h1234_ABCD;
        blank_lz  = 1'b0;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("init_an",  {24'h0, an},  32'h0000_00FF);
        check("init_seg", {25'h0, seg}, 32'h0000_007F);
        check("init_fd",  {31'h0, frame_done}, 32'h0);
        rst = 1'b1;

        // 1234ABCD scanned right-to-left
        sync_fd();
        capture_frame(-1, 32'h0);
        expect_frame("word_1234abcd", 8'hFF,
                     {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});

        // change during digit 3 must not disturb the current frame
        capture_frame(14, 32'hFFFF_FFFF);
        expect_frame("mid_frame_change", 8'hFF,
                     {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
        capture_frame(-1, 32'h0);
        expect_frame("all_f", 8'hFF, {8{7'h0E}});

        // leading-zero blanking
        blank_lz  = 1'b1;
        gpio_word = 32'h0000_00A0;
        capture_frame(-1, 32'h0);
        expect_frame("blank_a0", 8'h03, {42'h0, 7'h08, 7'h40});
        gpio_word = 32'h0;
        capture_frame(-1, 32'h0);
        expect_frame("blank_zero", 8'h01, {49'h0, 7'h40});

        // hold freezes the snapshot across frame boundaries
        gpio_word = 32'h5;
        capture_frame(-1, 32'h0);
        expect_frame("show_5", 8'h01, {49'h0, 7'h12});
        hold      = 1'b1;
        gpio_word = 32'h9;
        capture_frame(-1, 32'h0);
        expect_frame("hold_1", 8'h01, {49'h0, 7'h12});
        capture_frame(-1, 32'h0);
        expect_frame("hold_2", 8'h01, {49'h0, 7'h12});
        hold = 1'b0;
        capture_frame(-1, 32'h0);
        expect_frame("unhold_9", 8'h01, {49'h0, 7'h10});
        blank_lz = 1'b0;

        // asynchronous reset in the middle of a slot
        reset_mid_slot(7);

        // randomized traffic, with one more reset at a random point
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 19) == 0) gpio_word = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 24) == 0) hold = 1'($urandom_range(0, 1));
            if (c == 300) reset_mid_slot($urandom_range(1, FRAME));
        end

        repeat (3) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_hex_display.md
Name: gpio_hex_display

Overview:
- Downstream consumer of the CPU's 32-bit gpio_out word.
- Drives an 8-digit, common-anode, time-multiplexed seven-segment display that shows the word as 8 hex digits.
- Takes a frame-coherent snapshot of gpio_out so a digit never changes mid-frame.
- Provides a prescaled digit scan, ghosting guard, optional leading-zero blanking, hold/freeze and an end-of-frame pulse.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is scanned (min 2).
- GUARD_CYC, 16, cycles at the start of each digit slot with all anodes off (0 to SCAN_DIV-1).

Ports:
- clk  input  1  system clock, shared with the CPU.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- gpio_word  input  32  connects to the CPU's gpio_out.
- blank_lz  input  1  1 = blank leading zero digits.
- hold  input  1  1 = keep the current snapshot (freeze the display).
- an  output  8  anode enables, active-low, one-hot; an[i] selects digit i, digit 0 is rightmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt=0, idx=0, snap=0.
  - an=8'hFF, seg=7'h7F, frame_done=0.
  - All outputs hold these values while rst=0.
- Prescaler cnt, range 0..SCAN_DIV-1:
  - Increments every clock.
  - tick = (cnt==SCAN_DIV-1); on tick cnt wraps to 0.
- Digit index idx, range 0..7:
  - Increments on tick; wraps 7->0.
  - frame_done is registered and equals 1 in the cycle after a tick with idx==7.
- Snapshot load:
  - snap <= gpio_word in any cycle where idx==0, cnt==0 and hold==0.
  - Includes the first cycle after reset release.
  - hold sampled 1 at that cycle: snap is unchanged for the whole frame.
  - gpio_word changes at any other time have no effect until the next frame start.
- Nibble for digit i: snap[4i+3:4i].
- Blanking:
  - Digit i is blank when blank_lz==1, i>0, and every nibble j>=i is 0.
  - Digit 0 is never blank, so 0x00000000 shows a single "0".
  - Blanking is evaluated against snap, not gpio_word.
- Outputs are registered, 1-cycle latency from (cnt, idx, snap).
  - cnt < GUARD_CYC: an=8'hFF, seg=7'h7F.
  - Else, digit blank: an=8'hFF, seg=7'h7F.
  - Else: an = ~(8'b1 << idx), seg = decode(nibble).
- Decode table (hex, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Full frame = 8*SCAN_DIV cycles; frame_done period is exactly 8*SCAN_DIV.
- Reset mid-frame: immediate return to reset values. After release, scanning restarts at digit 0 with a fresh snapshot.
- blank_lz changes take effect on the next registered output cycle; no frame alignment.
- Never more than one an bit low in any cycle.

Test Plan:
- Reset, then gpio_word=32'h1234ABCD, SCAN_DIV=4, GUARD_CYC=1, blank_lz=0 -> for idx 0..7 the active-slot an/seg pairs are (FE,21), (FD,46), (FB,03), (F7,08), (EF,19), (DF,30), (BF,24), (7F,79). frame_done pulses every 32 cycles.
- gpio_word changes to 32'hFFFFFFFF during digit 3 of a frame -> digits 4..7 still show the old value. The next frame shows every digit with seg=0E.
- blank_lz=1, gpio_word=32'h000000A0 -> only digits 0 (seg=40) and 1 (seg=08) ever enable an. gpio_word=0 -> only digit 0 is enabled, showing seg=40.
- hold=1 across a frame boundary while gpio_word changes 5->9 -> the display stays "5" until hold=0 at a frame start, then shows "9".
- Guard check: in the first GUARD_CYC cycles of every slot an=FF. At most one an bit is low in all cycles (assertion).
- Assert rst=0 asynchronously mid-slot (not on a clock edge) -> an=FF, seg=7F, frame_done=0 immediately. After release, the first enabled digit is digit 0 at cycle GUARD_CYC+1.
